// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan sequencer: state encoding, widths
// and the index stepping helpers used by the top-level FSM.
package scan_pkg;

  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } scan_state_e;

  // Next slot index, wrapping between 0 and last in either direction.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                  input logic             down,
                                                  input logic [IDX_W-1:0] last);
    if (down) begin
      return (idx == '0) ? last : idx - 1'b1;
    end else begin
      return (idx == last) ? '0 : idx + 1'b1;
    end
  endfunction

  function automatic logic is_wrap(input logic [IDX_W-1:0] idx,
                                   input logic             down,
                                   input logic [IDX_W-1:0] last);
    if (down) begin
      return (idx == '0);
    end else begin
      return (idx == last);
    end
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_slot_timer.sv
// Phase timer for one scan slot: loaded with (phase length - 1) on entry to a
// phase, then counts down; done marks the last cycle of the phase.
module scan_slot_timer
  import scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = enable && (count_q == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for the 3-to-8 decoder: steps I through 0..LAST, holding en
// low for a blanking gap at the start of every slot. Free-run or single-step.
module decoder_scan_ctrl
  import scan_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1,
  parameter int LAST     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dir,
  input  logic             step,
  output logic             en,
  output logic [IDX_W-1:0] I,
  output logic             wrap,
  output logic             busy
);

  // Timer loads are phase length minus one because the loaded cycle counts.
  localparam logic [CNT_W-1:0] BLANK_LOAD  = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [CNT_W-1:0] ACTIVE_LOAD = CNT_W'(PRESCALE - BLANK - 1);
  localparam logic [CNT_W-1:0] FIRST_LOAD  = (BLANK > 0) ? BLANK_LOAD : ACTIVE_LOAD;
  localparam scan_state_e      FIRST_STATE = (BLANK > 0) ? ST_BLANK : ST_ACTIVE;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(LAST);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             single_q, single_d;
  logic             wrap_q, wrap_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_done;

  scan_slot_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (state_q != ST_IDLE),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      single_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      single_q <= single_d;
      wrap_q   <= wrap_d;
    end
  end

  // A slot always runs to completion; run and the single-shot flag are only
  // consulted on the final ACTIVE cycle, when the index advances.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    single_d   = single_q;
    wrap_d     = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d    = FIRST_STATE;
          timer_load = 1'b1;
          timer_val  = FIRST_LOAD;
          single_d   = !run;
        end
      end
      ST_BLANK: begin
        if (timer_done) begin
          state_d    = ST_ACTIVE;
          timer_load = 1'b1;
          timer_val  = ACTIVE_LOAD;
        end
      end
      ST_ACTIVE: begin
        if (timer_done) begin
          idx_d  = next_index(idx_q, dir, LAST_IDX);
          wrap_d = is_wrap(idx_q, dir, LAST_IDX);
          if (run && !single_q) begin
            state_d    = FIRST_STATE;
            timer_load = 1'b1;
            timer_val  = FIRST_LOAD;
          end else begin
            state_d  = ST_IDLE;
            single_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign en   = (state_q == ST_ACTIVE);
  assign busy = (state_q != ST_IDLE);
  assign I    = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: default, LAST=5 and BLANK=0/PRESCALE=2
// instances; expected outputs are queued per cycle and compared after each edge.
module tb_decoder_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       run_m, dir_m, step_m;
  logic       en_m, wrap_m, busy_m;
  logic [2:0] i_m;
  logic       run_l, dir_l, step_l;
  logic       en_l, wrap_l, busy_l;
  logic [2:0] i_l;
  logic       run_b, dir_b, step_b;
  logic       en_b, wrap_b, busy_b;
  logic [2:0] i_b;

  typedef struct {
    string      tag;
    int         unit_sel;
    logic [5:0] expv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  decoder_scan_ctrl #(.PRESCALE(4), .BLANK(1), .LAST(7)) u_main (
    .clk(clk), .rst(rst), .run(run_m), .dir(dir_m), .step(step_m),
    .en(en_m), .I(i_m), .wrap(wrap_m), .busy(busy_m)
  );

  decoder_scan_ctrl #(.PRESCALE(4), .BLANK(1), .LAST(5)) u_last5 (
    .clk(clk), .rst(rst), .run(run_l), .dir(dir_l), .step(step_l),
    .en(en_l), .I(i_l), .wrap(wrap_l), .busy(busy_l)
  );

  decoder_scan_ctrl #(.PRESCALE(2), .BLANK(0), .LAST(7)) u_noblank (
    .clk(clk), .rst(rst), .run(run_b), .dir(dir_b), .step(step_b),
    .en(en_b), .I(i_b), .wrap(wrap_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] sample(input int u);
    case (u)
      1:       return {en_l, i_l, wrap_l, busy_l};
      2:       return {en_b, i_b, wrap_b, busy_b};
      default: return {en_m, i_m, wrap_m, busy_m};
    endcase
  endfunction

  task automatic push_expect(input int u, input string tag, input logic e,
                             input logic [2:0] i, input logic w, input logic b);
    exp_t x;
    x.tag      = tag;
    x.unit_sel = u;
    x.expv     = {e, i, w, b};
    sb.push_back(x);
  endtask

  task automatic check_output();
    exp_t       x;
    logic [5:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: observed no entry, expected one");
    end else begin
      x   = sb.pop_front();
      obs = sample(x.unit_sel);
      assert (obs === x.expv) else begin
        errors++;
        $error("[TB] FAIL %s: observed en/I/wrap/busy=%b/%0d/%b/%b expected %b/%0d/%b/%b",
               x.tag, obs[5], obs[4:2], obs[1], obs[0],
               x.expv[5], x.expv[4:2], x.expv[1], x.expv[0]);
      end
    end
  endtask

  task automatic apply_stimulus(input int u, input string tag, input logic e,
                                input logic [2:0] i, input logic w, input logic b);
    push_expect(u, tag, e, i, w, b);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    rst    = 1'b1;
    run_m  = 1'b1; dir_m = 1'b0; step_m = 1'b0;
    run_l  = 1'b0; dir_l = 1'b0; step_l = 1'b0;
    run_b  = 1'b0; dir_b = 1'b0; step_b = 1'b0;

    // Reset held with run=1: everything stays cleared.
    apply_stimulus(0, "reset_hold", 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(0, "reset_hold", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Free run upward; slot k is one blank cycle then three enabled cycles.
    // run drops on the second active cycle of slot I=6; that slot completes.
    for (int k = 0; k < 15; k++) begin
      for (int c = 0; c < 4; c++) begin
        apply_stimulus(0, $sformatf("free_run_k%0d_c%0d", k, c), c != 0, 3'(k % 8),
                       (c == 0) && (k > 0) && (k % 8 == 0), 1'b1);
        if (k == 14 && c == 2) run_m = 1'b0;
      end
    end
    apply_stimulus(0, "run_drop_idle", 1'b0, 3'd7, 1'b0, 1'b0);
    apply_stimulus(0, "run_drop_idle", 1'b0, 3'd7, 1'b0, 1'b0);

    // Single steps downward from 7; the last slot (I=3) sees an ignored step.
    dir_m = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step_m = 1'b1;
      apply_stimulus(0, $sformatf("step_s%0d_blank", s), 1'b0, 3'(7 - s), 1'b0, 1'b1);
      step_m = 1'b0;
      for (int c = 1; c < 4; c++) begin
        apply_stimulus(0, $sformatf("step_s%0d_active", s), 1'b1, 3'(7 - s), 1'b0, 1'b1);
        step_m = (s == 4) && (c == 1);
      end
      for (int n = 0; n < ((s == 4) ? 4 : 2); n++) begin
        apply_stimulus(0, $sformatf("step_s%0d_idle", s), 1'b0, 3'(6 - s), 1'b0, 1'b0);
      end
    end

    // Asynchronous reset in the middle of a blanking cycle.
    dir_m = 1'b0;
    run_m = 1'b1;
    apply_stimulus(0, "pre_reset_blank", 1'b0, 3'd2, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    push_expect(0, "async_reset_now", 1'b0, 3'd0, 1'b0, 1'b0);
    check_output();
    run_m = 1'b0;
    apply_stimulus(0, "async_reset_held", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    apply_stimulus(0, "post_reset_idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // LAST=5 counting down from 0: 0,5,4,3,2,1,0,5 with wrap on each 5.
    dir_l = 1'b1;
    run_l = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        apply_stimulus(1, $sformatf("last5_k%0d_c%0d", k, c), c != 0, 3'((6 - k % 6) % 6),
                       (c == 0) && (k > 0) && ((6 - k % 6) % 6 == 5), 1'b1);
        if (k == 7 && c == 3) run_l = 1'b0;
      end
    end
    apply_stimulus(1, "last5_idle", 1'b0, 3'd4, 1'b0, 1'b0);

    // BLANK=0, PRESCALE=2: en never drops while running, I advances every 2.
    run_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 2; c++) begin
        apply_stimulus(2, $sformatf("noblank_k%0d_c%0d", k, c), 1'b1, 3'(k % 8),
                       (c == 0) && (k > 0) && (k % 8 == 0), 1'b1);
        if (k == 9 && c == 1) run_b = 1'b0;
      end
    end
    apply_stimulus(2, "noblank_idle", 1'b0, 3'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
